// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS fetch stage with imem req/ready, decoder valid/ready and redirect squash
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] redirect_base,
  input  logic [15:0] redirect_imm,
  input  logic [25:0] redirect_jaddr,
  input  logic [31:0] redirect_reg
);
  typedef enum logic [1:0] {FETCH, HOLD, SQUASH} state_t;
  state_t state;
  logic [31:0] pc, sq_addr, base4, target;
  logic redir;
  always_comb begin
    base4 = redirect_base + 32'd4;
    target = redirect_kind == 2'b00 ? base4 + {{14{redirect_imm[15]}}, redirect_imm, 2'b00}
           : redirect_kind == 2'b01 ? {base4[31:28], redirect_jaddr, 2'b00}
           : redirect_reg & 32'hFFFF_FFFC;
  end
  assign redir = redirect_valid && redirect_kind != 2'b11;
  assign imem_req = reset_n && state != HOLD;
  assign imem_addr = state == SQUASH ? sq_addr : pc;
  assign inst_pc4 = inst_pc + 32'd4;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= FETCH;
      pc <= RESET_PC;
      sq_addr <= RESET_PC;
      inst_valid <= 1'b0;
      inst <= 32'd0;
      inst_pc <= 32'd0;
    end else if (redir) begin
      pc <= target;
      inst_valid <= 1'b0;
      if (state == FETCH) sq_addr <= pc;
      state <= state != HOLD && !imem_ready ? SQUASH : FETCH;
    end else if (state == FETCH) begin
      if (imem_ready) begin
        inst <= imem_rdata;
        inst_pc <= pc;
        pc <= pc + 32'd4;
        inst_valid <= 1'b1;
        state <= HOLD;
      end
    end else if (state == HOLD) begin
      if (inst_ready) begin
        inst_valid <= 1'b0;
        state <= FETCH;
      end
    end else if (imem_ready) state <= FETCH;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized and directed self-checking bench for instruction_fetch
module tb_instruction_fetch;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 1'b0, reset_n = 1'b0;
  logic imem_req, imem_ready = 1'b0, inst_valid, inst_ready = 1'b1;
  logic [31:0] imem_addr, imem_rdata = 32'd0, inst, inst_pc, inst_pc4;
  logic redirect_valid = 1'b0;
  logic [1:0] redirect_kind = 2'b00;
  logic [31:0] redirect_base = 32'd0, redirect_reg = 32'd0;
  logic [15:0] redirect_imm = 16'd0;
  logic [25:0] redirect_jaddr = 26'd0;
  int checks = 0, passed = 0;
  int ws = 0, ws_fixed = 0, cnt = 0;
  bit ws_rand = 1'b0;
  instruction_fetch dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
    .redirect_valid(redirect_valid), .redirect_kind(redirect_kind), .redirect_base(redirect_base),
    .redirect_imm(redirect_imm), .redirect_jaddr(redirect_jaddr), .redirect_reg(redirect_reg)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset_n || !imem_req) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      if (!reset_n) cnt = 0;
    end else if (cnt >= ws) begin
      imem_ready = 1'b1;
      imem_rdata = imem_addr ^ K;
      cnt = 0;
      ws = ws_rand ? int'($urandom_range(0, 3)) : ws_fixed;
    end else begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      cnt++;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic logic [31:0] ref_target(input logic [1:0] k, input logic [31:0] b,
                                             input logic [15:0] im, input logic [25:0] ja, input logic [31:0] r);
    int off;
    off = int'($signed(im));
    if (k == 2'd0) return b + 32'd4 + 32'(off * 4);
    if (k == 2'd1) return ((b + 32'd4) & 32'hF000_0000) | (32'(ja) << 2);
    return r & 32'hFFFF_FFFC;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic redirect(input logic [1:0] k, input logic [31:0] b, input logic [15:0] im,
                          input logic [25:0] ja, input logic [31:0] r);
    tick;
    redirect_valid = 1'b1;
    redirect_kind = k;
    redirect_base = b;
    redirect_imm = im;
    redirect_jaddr = ja;
    redirect_reg = r;
    tick;
    redirect_valid = 1'b0;
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req); else passed++;
    checks++; if (imem_addr !== 32'd0) $display("FAIL reset_addr: got %h expected 0", imem_addr); else passed++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", inst_valid); else passed++;
    checks++; if (inst !== 32'd0) $display("FAIL reset_inst: got %h expected 0", inst); else passed++;
    checks++; if (inst_pc !== 32'd0) $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); else passed++;
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) $display("FAIL release_req: got %b expected 1", imem_req); else passed++;
    checks++; if (imem_addr !== 32'd0) $display("FAIL release_addr: got %h expected 0", imem_addr); else passed++;
  endtask
  task automatic test_stream;
    logic [31:0] e;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'(c % 2)) $display("FAIL stream_valid c=%0d: got %b expected %b", c, inst_valid, c % 2); else passed++;
      if (c % 2 == 1) begin
        e = 32'((c / 2) * 4);
        checks++; if (inst_pc !== e) $display("FAIL stream_pc: got %h expected %h", inst_pc, e); else passed++;
        checks++; if (inst !== (e ^ K)) $display("FAIL stream_inst: got %h expected %h", inst, e ^ K); else passed++;
      end
    end
  endtask
  task automatic test_stall;
    bit ok;
    tick;
    inst_ready = 1'b0;
    wait_valid(10, ok);
    checks++; if (!ok) $display("FAIL stall_wait: got timeout expected inst_valid"); else passed++;
    checks++; if (inst_pc !== 32'h10) $display("FAIL stall_pc: got %h expected 00000010", inst_pc); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst !== (32'h10 ^ K) || imem_req !== 1'b0)
        $display("FAIL stall_hold: got v=%b pc=%h inst=%h req=%b expected v=1 pc=00000010 inst=%h req=0",
                 inst_valid, inst_pc, inst, imem_req, 32'h10 ^ K);
      else passed++;
    end
    tick;
    inst_ready = 1'b1;
    @(negedge clk);
    wait_valid(10, ok);
    checks++; if (!ok || inst_pc !== 32'h14) $display("FAIL stall_resume: got ok=%b pc=%h expected pc=00000014", ok, inst_pc); else passed++;
  endtask
  task automatic test_branch;
    bit ok;
    tick;
    inst_ready = 1'b0;
    wait_valid(10, ok);
    checks++; if (!ok || inst_pc !== 32'h18) $display("FAIL branch_pre: got ok=%b pc=%h expected pc=00000018", ok, inst_pc); else passed++;
    redirect(2'b00, 32'h40, 16'hFFFE, 26'd0, 32'd0);
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) $display("FAIL branch_clear: got %b expected 0", inst_valid); else passed++;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3C) $display("FAIL branch_addr: got req=%b addr=%h expected req=1 addr=0000003c", imem_req, imem_addr); else passed++;
    wait_valid(10, ok);
    checks++; if (!ok || inst_pc !== 32'h3C || inst !== (32'h3C ^ K)) $display("FAIL branch_deliver: got pc=%h inst=%h expected pc=0000003c inst=%h", inst_pc, inst, 32'h3C ^ K); else passed++;
  endtask
  task automatic test_jump_squash;
    bit ok;
    ws = 3;
    ws_fixed = 3;
    tick;
    inst_ready = 1'b1;
    tick;
    redirect_valid = 1'b1;
    redirect_kind = 2'b01;
    redirect_base = 32'h1000_0010;
    redirect_jaddr = 26'h0000100;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) $display("FAIL jump_fetch: got req=%b addr=%h expected req=1 addr=00000040", imem_req, imem_addr); else passed++;
    tick;
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) $display("FAIL jump_squash_hold: got req=%b addr=%h expected req=1 addr=00000040", imem_req, imem_addr); else passed++;
    end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000_0400 || inst_valid !== 1'b0)
      $display("FAIL jump_target: got req=%b addr=%h v=%b expected req=1 addr=10000400 v=0", imem_req, imem_addr, inst_valid);
    else passed++;
    wait_valid(12, ok);
    checks++; if (!ok || inst_pc !== 32'h1000_0400 || inst !== (32'h1000_0400 ^ K)) $display("FAIL jump_deliver: got pc=%h inst=%h expected pc=10000400", inst_pc, inst); else passed++;
    ws_fixed = 0;
    ws = 0;
  endtask
  task automatic test_jr_reserved;
    bit ok;
    tick;
    inst_ready = 1'b0;
    redirect(2'b10, 32'd0, 16'd0, 26'd0, 32'h0000_2003);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) $display("FAIL jr_addr: got req=%b addr=%h expected req=1 addr=00002000", imem_req, imem_addr); else passed++;
    wait_valid(10, ok);
    checks++; if (!ok || inst_pc !== 32'h2000) $display("FAIL jr_deliver: got pc=%h expected 00002000", inst_pc); else passed++;
    redirect(2'b11, 32'h0000_8000, 16'h0010, 26'h3FFFFFF, 32'h0000_5554);
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h2000 || imem_req !== 1'b0)
      $display("FAIL reserved_kind: got v=%b pc=%h req=%b expected v=1 pc=00002000 req=0", inst_valid, inst_pc, imem_req);
    else passed++;
    tick;
    inst_ready = 1'b1;
    @(negedge clk);
    wait_valid(10, ok);
    checks++; if (!ok || inst_pc !== 32'h2004) $display("FAIL reserved_next: got pc=%h expected 00002004", inst_pc); else passed++;
  endtask
  task automatic test_wrap;
    bit ok;
    logic [31:0] e;
    redirect(2'b10, 32'd0, 16'd0, 26'd0, 32'hFFFF_FFF8);
    e = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      wait_valid(10, ok);
      checks++; if (!ok || inst_pc !== e || inst_pc4 !== e + 32'd4 || inst !== (e ^ K))
        $display("FAIL wrap: got pc=%h pc4=%h inst=%h expected pc=%h pc4=%h", inst_pc, inst_pc4, inst, e, e + 32'd4);
      else passed++;
      e = e + 32'd4;
    end
  endtask
  task automatic test_async_reset;
    bit ok;
    tick;
    inst_ready = 1'b0;
    wait_valid(10, ok);
    checks++; if (!ok) $display("FAIL areset_pre: got timeout expected inst_valid"); else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'd0 || inst_pc !== 32'd0)
      $display("FAIL areset_now: got v=%b req=%b addr=%h pc=%h expected all 0", inst_valid, imem_req, imem_addr, inst_pc);
    else passed++;
    @(negedge clk);
    #2 reset_n = 1'b1;
    inst_ready = 1'b1;
    wait_valid(10, ok);
    checks++; if (!ok || inst_pc !== 32'd0 || inst !== K) $display("FAIL areset_restart: got pc=%h inst=%h expected pc=00000000 inst=%h", inst_pc, inst, K); else passed++;
  endtask
  task automatic test_random;
    logic [31:0] exp_pc, prev_addr;
    bit prev_wait;
    int n;
    ws_rand = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    exp_pc = 32'd0;
    prev_wait = 1'b0;
    prev_addr = 32'd0;
    n = 0;
    for (int c = 0; c < 1500; c++) begin
      tick;
      inst_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 7) == 0;
      redirect_kind = 2'($urandom);
      redirect_base = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 | ($urandom & 32'hC) : $urandom & 32'hFFFF_FFFC;
      redirect_imm = 16'($urandom);
      redirect_jaddr = 26'($urandom);
      redirect_reg = $urandom;
      @(negedge clk);
      if (prev_wait) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) $display("FAIL rand_req_stable: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, prev_addr); else passed++;
      end
      checks++; if ((imem_req & inst_valid) !== 1'b0) $display("FAIL rand_req_in_hold: got req=%b valid=%b expected not both", imem_req, inst_valid); else passed++;
      if (inst_valid && inst_ready) begin
        checks++; if (inst_pc !== exp_pc || inst !== (exp_pc ^ K) || inst_pc4 !== exp_pc + 32'd4)
          $display("FAIL rand_transfer: got pc=%h inst=%h pc4=%h expected pc=%h inst=%h", inst_pc, inst, inst_pc4, exp_pc, exp_pc ^ K);
        else passed++;
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      if (redirect_valid && redirect_kind != 2'b11)
        exp_pc = ref_target(redirect_kind, redirect_base, redirect_imm, redirect_jaddr, redirect_reg);
      prev_wait = imem_req && !imem_ready;
      prev_addr = imem_addr;
    end
    checks++; if (n < 100) $display("FAIL rand_progress: got %0d transfers expected at least 100", n); else passed++;
    redirect_valid = 1'b0;
    ws_rand = 1'b0;
  endtask
  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_branch;
    test_jump_squash;
    test_jr_reserved;
    test_wrap;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the MIPS datapath: holds the program counter, issues word reads to instruction memory over a req/ready handshake, and presents one fetched instruction word (with its PC) to the instruction decoder over a valid/ready handshake. It accepts control-flow redirects from downstream (branch, jump/jal, jr), computes the target address itself, and squashes any stale fetch. It sits directly upstream of the decoder that splits the word into opcode/rs/rt/rd/shamt/funct/imm/jump-address fields.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request; held high until imem_ready.
- imem_addr  out  32  word address of the read; stable while imem_req high.
- imem_ready  in  1  read complete this cycle; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst/inst_pc hold an instruction for the decoder.
- inst_ready  in  1  decoder accepts; transfer when inst_valid & inst_ready.
- inst  out  32  instruction word for the decoder.
- inst_pc  out  32  address of inst.
- inst_pc4  out  32  inst_pc + 4.
- redirect_valid  in  1  one-cycle pulse: change fetch stream.
- redirect_kind  in  2  00 branch, 01 jump/jal, 10 jr, 11 reserved (ignored, no redirect).
- redirect_base  in  32  PC of the redirecting instruction.
- redirect_imm  in  16  branch offset field.
- redirect_jaddr  in  26  jump address field.
- redirect_reg  in  32  rs value for jr.

## Operation
- Registers: pc (next address to fetch), inst, inst_pc, inst_valid, 2-bit state.
- States: FETCH (imem_req=1, imem_addr=pc), HOLD (inst_valid=1, imem_req=0), SQUASH (imem_req=1, same address, response discarded).
- FETCH: on imem_ready, capture inst=imem_rdata and inst_pc=pc, set pc=pc+4, go to HOLD.
- HOLD: on inst_ready, clear inst_valid and go to FETCH.
- SQUASH: on imem_ready, drop the data and go to FETCH at the already-loaded redirect target.
- Redirect targets (all arithmetic mod 2^32):
  - branch: base + 4 + (sign-extended imm << 2).
  - jump: {(base+4)[31:28], jaddr, 2'b00}.
  - jr: {reg[31:2], 2'b00}.
- Redirect always loads pc with the target. Redirect has priority over every other event in the same cycle.
- Redirect in FETCH without imem_ready: go to SQUASH. The outstanding request is not withdrawn.
- Redirect in FETCH with imem_ready: data discarded, go to FETCH at the target.
- Redirect in HOLD: inst_valid cleared, go to FETCH.
- Redirect in SQUASH: pc updated to the new target, state unchanged.
- No delay slot: only instructions at the target and beyond are delivered after a redirect. A transfer that completes in the redirect cycle is still a completed transfer; the decoder side is responsible for ignoring it.
- inst_pc4 = inst_pc + 4, combinational.

## Timing
- Reset (async assert): state=FETCH, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0. imem_req is forced 0 while reset_n=0; imem_addr=RESET_PC.
- First cycle after release: imem_req=1, imem_addr=RESET_PC.
- Latency: imem_ready in cycle N gives inst_valid=1 in cycle N+1.
- Zero-wait memory with a decoder that is always ready: one instruction every 2 cycles.
- Stall: inst/inst_pc stay stable while inst_valid=1 and inst_ready=0.
- Redirect in cycle N: the first request to the target is issued in cycle N+1 (from FETCH or HOLD), or after the discarded response (from SQUASH).
- Reset mid-fetch: the outstanding request is abandoned; instruction memory must tolerate a dropped request.
- PC wraps from 32'hFFFF_FFFC to 0.

## Test plan
- Reset release, zero-wait memory returning addr^32'hA5A5_0000, inst_ready=1 -> inst_pc sequence 0,4,8,C; inst_valid high every other cycle.
- inst_ready low 5 cycles during HOLD -> inst/inst_pc stable, imem_req=0 throughout, then resumes at the next PC.
- Branch redirect, base=0x40, imm=16'hFFFE, in HOLD -> next imem_addr=0x3C; held instruction never transferred.
- Redirect (jump, base=0x1000_0010, jaddr=0x0000100) during a 3-wait-state fetch -> imem_addr held until imem_ready, response discarded, next imem_addr=0x1000_0400.
- jr with reg=0x0000_2003 -> fetch 0x2000; kind=11 -> no change to pc or state.
- reset_n pulsed low mid-HOLD -> inst_valid=0 immediately (async), fetch restarts at RESET_PC.
